// File: rtl/counter_seq_ctrl_pkg.sv
// Shared definitions for the counter sequencing controller: FSM state encodings
// (also used by the LED decode) and the press-edge helper.
package counter_seq_ctrl_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // A press is the accepted (active-low) level going from released to pressed.
    function automatic logic press_edge(input logic level_prev, input logic level_next);
        return level_prev & ~level_next;
    endfunction

endpackage

// File: rtl/counter_seq_ctrl_btn_debounce.sv
// Button conditioner: 2-flop synchronizer, debounce counter and one-cycle
// press pulse on the falling edge of the accepted level.
module btn_debounce
    import counter_seq_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_ni,
    output logic press_o
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    // Count consecutive synchronized samples that disagree with the accepted level.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync_q[1] == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = sync_q[1];
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        press_d = press_edge(level_q, level_d);
    end

    // Synchronizer and debounce state; reset to the released level so no press is faked.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_ni};
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/counter_seq_ctrl.sv
// Sequencing controller for the enable/clear counter: debounced run/clear buttons,
// prescaled count-enable pulses and limit detection. Option: COUNTER_SEQ_AUTORELOAD_EN.
module counter_seq_ctrl
    import counter_seq_ctrl_pkg::*;
#(
    parameter int unsigned PRESCALE        = 50000000,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned WIDTH           = 8
) (
    input  logic               CLOCK_50,
    input  logic               RESET_N,
    input  logic               BTN_RUN_N,
    input  logic               BTN_CLR_N,
    input  logic [WIDTH-1:0]   LIMIT,
    input  logic [WIDTH-1:0]   Q,
    output logic               CNT_EN,
    output logic               CNT_CLR,
    output logic [STATE_W-1:0] STATE,
    output logic               DONE
);

    localparam int unsigned      PRE_W    = $clog2(PRESCALE);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    state_e           state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             cnt_en_q, cnt_en_d;
    logic             cnt_clr_q, cnt_clr_d;
    logic             done_q, done_d;
    logic             run_press_s, clr_press_s;
    logic             at_limit_s, tick_s, reload_s;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_run (
        .clk_i   (CLOCK_50),
        .rst_ni  (RESET_N),
        .btn_ni  (BTN_RUN_N),
        .press_o (run_press_s)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_clr (
        .clk_i   (CLOCK_50),
        .rst_ni  (RESET_N),
        .btn_ni  (BTN_CLR_N),
        .press_o (clr_press_s)
    );

    assign at_limit_s = (Q == LIMIT);
    assign tick_s     = (state_q == ST_RUN) && (pre_q == PRE_LAST);

    // Next-state logic; a clear press overrides everything, including a simultaneous run press.
    always_comb begin
        state_d  = state_q;
        reload_s = 1'b0;
        if (clr_press_s) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (run_press_s) state_d = ST_RUN;
                    else             state_d = ST_IDLE;
                end
                ST_RUN: begin
                    if (run_press_s) begin
                        state_d = ST_PAUSE;
                    end else if (at_limit_s) begin
`ifdef COUNTER_SEQ_AUTORELOAD_EN
                        // Q stays at LIMIT until the counter acts on CNT_CLR; reload only once.
                        state_d  = ST_RUN;
                        reload_s = ~cnt_clr_q;
`else
                        state_d  = ST_DONE;
`endif
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_PAUSE: begin
                    if (run_press_s) state_d = ST_RUN;
                    else             state_d = ST_PAUSE;
                end
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Prescaler and registered output pulses.
    always_comb begin
        pre_d = pre_q;
        if (clr_press_s) begin
            pre_d = '0;
        end else if ((state_q == ST_IDLE) && (state_d == ST_RUN)) begin
            pre_d = '0;
        end else if (state_q == ST_RUN) begin
            pre_d = tick_s ? '0 : pre_q + PRE_W'(1);
        end else begin
            pre_d = pre_q;
        end
        cnt_en_d  = tick_s && !at_limit_s && !clr_press_s;
        cnt_clr_d = clr_press_s | reload_s;
`ifdef COUNTER_SEQ_AUTORELOAD_EN
        done_d    = reload_s;
`else
        done_d    = (state_d == ST_DONE);
`endif
    end

    // State, prescaler and output registers.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= ST_IDLE;
            pre_q     <= '0;
            cnt_en_q  <= 1'b0;
            cnt_clr_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            cnt_en_q  <= cnt_en_d;
            cnt_clr_q <= cnt_clr_d;
            done_q    <= done_d;
        end
    end

    assign CNT_EN  = cnt_en_q;
    assign CNT_CLR = cnt_clr_q;
    assign STATE   = state_q;
    assign DONE    = done_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Scoreboard bench for counter_seq_ctrl (PRESCALE=4, DEBOUNCE_CYCLES=3) with a
// behavioural counter closing the Q loop; honours COUNTER_SEQ_AUTORELOAD_EN.
module tb_counter_seq_ctrl;

    typedef struct packed {
        logic       clr;
        logic [7:0] q;
        logic [1:0] st;
        logic [7:0] gap;
    } evt_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_run_n = 1'b1;
    logic       btn_clr_n = 1'b1;
    logic [7:0] limit = 8'd5;
    logic [7:0] q;
    logic       cnt_en, cnt_clr, done;
    logic [1:0] state;

    evt_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_cyc = 0;
    int   done_cnt = 0;
    logic saw_done_state = 1'b0;

    counter_seq_ctrl #(.PRESCALE(4), .DEBOUNCE_CYCLES(3), .WIDTH(8)) dut (
        .CLOCK_50  (clk),
        .RESET_N   (rst_n),
        .BTN_RUN_N (btn_run_n),
        .BTN_CLR_N (btn_clr_n),
        .LIMIT     (limit),
        .Q         (q),
        .CNT_EN    (cnt_en),
        .CNT_CLR   (cnt_clr),
        .STATE     (state),
        .DONE      (done)
    );

    always #5 clk = ~clk;

    // Behavioural enable/clear counter fed by the DUT.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)       q <= 8'd0;
        else if (cnt_clr) q <= 8'd0;
        else if (cnt_en)  q <= q + 8'd1;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every CNT_EN/CNT_CLR pulse must match the next expected event.
    always @(negedge clk) begin
        if (done) done_cnt = done_cnt + 1;
        if (state == 2'd3) saw_done_state = 1'b1;
        if (rst_n && (cnt_en || cnt_clr)) begin
            n_cmp = n_cmp + 1;
            if (exp_q.size() == 0) begin
                n_err = n_err + 1;
                $display("FAIL unexpected_pulse: en=%0b clr=%0b q=%0d state=%0d, required no pulse",
                         cnt_en, cnt_clr, q, state);
            end else begin
                evt_t e;
                e = exp_q.pop_front();
                if ({cnt_en, cnt_clr, q, state} !== {~e.clr, e.clr, e.q, e.st}) begin
                    n_err = n_err + 1;
                    $display("FAIL pulse_event: got en=%0b clr=%0b q=%0d st=%0d, required en=%0b clr=%0b q=%0d st=%0d",
                             cnt_en, cnt_clr, q, state, ~e.clr, e.clr, e.q, e.st);
                end
                if (e.gap != 8'd0) begin
                    n_cmp = n_cmp + 1;
                    if (cyc - last_cyc != int'(e.gap)) begin
                        n_err = n_err + 1;
                        $display("FAIL pulse_gap: got %0d cycles, required %0d", cyc - last_cyc, e.gap);
                    end
                end
            end
            last_cyc = cyc;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp = n_cmp + 1;
        if (act != exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic push_evt(input logic clr, input logic [7:0] qv, input logic [1:0] st, input logic [7:0] gap);
        evt_t e;
        e.clr = clr; e.q = qv; e.st = st; e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic press_run(input int n);
        btn_run_n = 1'b0;
        repeat (n) @(negedge clk);
        btn_run_n = 1'b1;
    endtask

    task automatic press_clr(input int n);
        btn_clr_n = 1'b0;
        repeat (n) @(negedge clk);
        btn_clr_n = 1'b1;
    endtask

    task automatic press_both(input int n);
        btn_run_n = 1'b0;
        btn_clr_n = 1'b0;
        repeat (n) @(negedge clk);
        btn_run_n = 1'b1;
        btn_clr_n = 1'b1;
    endtask

    task automatic wait_q(input logic [7:0] v, input string name);
        for (int i = 0; i < 200 && q != v; i++) @(negedge clk);
        check(name, int'(q), int'(v));
    endtask

    task automatic wait_state(input logic [1:0] v, input string name);
        for (int i = 0; i < 200 && state != v; i++) @(negedge clk);
        check(name, int'(state), int'(v));
    endtask

    // Cycles from RUN being observed to the next CNT_EN.
    task automatic check_run_latency(input int exp_lat, input string name);
        int t0;
        wait_state(2'd1, {name, "_run"});
        t0 = cyc;
        for (int i = 0; i < 50 && !cnt_en; i++) @(negedge clk);
        check({name, "_en_seen"}, int'(cnt_en), 1);
        check(name, cyc - t0, exp_lat);
    endtask

    initial begin
        int d0;
        repeat (3) @(negedge clk);
        check("rst_state", int'(state), 0);
        check("rst_en", int'(cnt_en), 0);
        check("rst_clr", int'(cnt_clr), 0);
        check("rst_done", int'(done), 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_state", int'(state), 0);

        press_run(2);
        repeat (20) @(negedge clk);
        check("glitch_state", int'(state), 0);

`ifdef COUNTER_SEQ_AUTORELOAD_EN
        limit = 8'd3;
        for (int w = 0; w < 2; w++) begin
            push_evt(1'b0, 8'd0, 2'd1, (w == 0) ? 8'd0 : 8'd2);
            push_evt(1'b0, 8'd1, 2'd1, 8'd4);
            push_evt(1'b0, 8'd2, 2'd1, 8'd4);
            push_evt(1'b1, 8'd3, 2'd1, 8'd2);
        end
        d0 = done_cnt;
        press_run(5);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        check("reload_events_left", exp_q.size(), 0);
        #2 rst_n = 1'b0;
        #1;
        check("reload_done_pulses", done_cnt - d0, 2);
        check("reload_never_done", int'(saw_done_state), 0);
        @(negedge clk) rst_n = 1'b1;
`else
        // Plain count to LIMIT=5 with a 10-cycle button hold.
        limit = 8'd5;
        push_evt(1'b0, 8'd0, 2'd1, 8'd0);
        for (int k = 1; k < 5; k++) push_evt(1'b0, 8'(k), 2'd1, 8'd4);
        fork press_run(10); join_none
        check_run_latency(4, "first_en_latency");
        wait_state(2'd3, "done_state");
        check("done_q", int'(q), 5);
        check("done_flag", int'(done), 1);
        repeat (20) @(negedge clk);
        limit = 8'd9;
        repeat (10) @(negedge clk);
        check("done_held_limit_change", int'(state), 3);
        press_run(5);
        repeat (15) @(negedge clk);
        check("done_ignores_run", int'(state), 3);
        check("done_still_high", int'(done), 1);
        limit = 8'd5;

        push_evt(1'b1, 8'd5, 2'd0, 8'd0);
        press_clr(5);
        repeat (15) @(negedge clk);
        check("clr_q", int'(q), 0);
        check("clr_state", int'(state), 0);
        check("clr_done", int'(done), 0);

        // Pause just after Q reaches 2 with the prescaler at 3; resume needs one more cycle.
        push_evt(1'b0, 8'd0, 2'd1, 8'd0);
        push_evt(1'b0, 8'd1, 2'd1, 8'd4);
        push_evt(1'b0, 8'd2, 2'd1, 8'd0);
        push_evt(1'b0, 8'd3, 2'd1, 8'd4);
        push_evt(1'b0, 8'd4, 2'd1, 8'd4);
        press_run(5);
        wait_q(8'd1, "pause_trigger");
        press_run(5);
        wait_state(2'd2, "pause_state");
        check("pause_q", int'(q), 2);
        repeat (20) @(negedge clk);
        check("pause_q_frozen", int'(q), 2);
        press_run(5);
        check_run_latency(1, "resume_en_latency");
        wait_state(2'd3, "pause_done_state");
        check("pause_done_q", int'(q), 5);
        push_evt(1'b1, 8'd5, 2'd0, 8'd0);
        press_clr(5);
        repeat (15) @(negedge clk);
        check("clr2_state", int'(state), 0);

        // Q already equals LIMIT on entry to RUN.
        limit = 8'd0;
        press_run(5);
        for (int i = 0; i < 50 && state == 2'd0; i++) @(negedge clk);
        check("lim0_run", int'(state), 1);
        @(negedge clk);
        check("lim0_done", int'(state), 3);
        check("lim0_done_flag", int'(done), 1);
        push_evt(1'b1, 8'd0, 2'd0, 8'd0);
        press_clr(5);
        repeat (15) @(negedge clk);
        check("lim0_clr_state", int'(state), 0);
`endif

        // Run and clear pressed together while counting: clear wins.
        limit = 8'd200;
        push_evt(1'b0, 8'd0, 2'd1, 8'd0);
        push_evt(1'b0, 8'd1, 2'd1, 8'd4);
        push_evt(1'b1, 8'd2, 2'd0, 8'd3);
        press_run(5);
        wait_q(8'd1, "both_trigger");
        press_both(5);
        repeat (15) @(negedge clk);
        check("both_state", int'(state), 0);
        check("both_q", int'(q), 0);

        // Asynchronous reset in the middle of a count.
        push_evt(1'b0, 8'd0, 2'd1, 8'd0);
        press_run(5);
        wait_q(8'd1, "rst_trigger");
        #2 rst_n = 1'b0;
        #1;
        check("midrst_state", int'(state), 0);
        check("midrst_en", int'(cnt_en), 0);
        check("midrst_clr", int'(cnt_clr), 0);
        check("midrst_done", int'(done), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_state", int'(state), 0);
        check("events_left", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
